// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode encoding, instruction field
// positions, offset sign extension and the RUN/HALT state encoding.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_e;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int OFF_HI = 5;
    localparam int OFF_LO = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic [7:0] sext6(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction

    // Unsigned compare against the instruction-memory depth (DEPTH may be 256).
    function automatic logic pc_in_range(input logic [7:0] pc, input int depth);
        return int'({24'd0, pc}) < depth;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_logic.sv
// Combinational next-PC computation: sequential or jump target, plus the
// jump-to-self and out-of-range flags that stop fetch.
module pc_next_logic
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic [7:0] pc_i,
    input  logic [7:0] instr_i,
    output logic [7:0] next_pc_o,
    output logic       jump_self_o,
    output logic       out_of_range_o
);

    opcode_e    op;
    logic [5:0] offset;
    logic [7:0] seq_pc;
    logic [7:0] jump_pc;
    logic       is_jump;

    always_comb begin
        op             = opcode_e'(instr_i[OPC_HI:OPC_LO]);
        offset         = instr_i[OFF_HI:OFF_LO];
        is_jump        = (op == OP_J);
        seq_pc         = pc_i + 8'd1;
        // Arithmetic wraps modulo 256 by virtue of the 8-bit width.
        jump_pc        = seq_pc + sext6(offset);
        next_pc_o      = is_jump ? jump_pc : seq_pc;
        jump_self_o    = is_jump && (offset == 6'h3F);
        out_of_range_o = !pc_in_range(next_pc_o, DEPTH);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the fetched byte into the IR,
// resolves jumps locally and honours redirect > stall > fetch priority.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       instruction,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [7:0]       redirect_pc,
    output logic [7:0]       pc_out,
    output logic [7:0]       ir,
    output logic [7:0]       ir_pc,
    output logic             ir_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output state_e           state_o
);

    state_e           state_q;
    logic [7:0]       pc_q;
    logic [7:0]       ir_q;
    logic [7:0]       ir_pc_q;
    logic             ir_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [7:0] next_pc;
    logic       jump_self;
    logic       out_of_range;

    pc_next_logic #(
        .DEPTH(DEPTH)
    ) u_pc_next (
        .pc_i          (pc_q),
        .instr_i       (instruction),
        .next_pc_o     (next_pc),
        .jump_self_o   (jump_self),
        .out_of_range_o(out_of_range)
    );

    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= 8'd0;
            ir_q       <= 8'd0;
            ir_pc_q    <= 8'd0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else if (redirect_valid) begin
            // A redirect flushes the IR and overrides stall in either state.
            pc_q       <= redirect_pc;
            ir_valid_q <= 1'b0;
            state_q    <= pc_in_range(redirect_pc, DEPTH) ? ST_RUN : ST_HALT;
        end else begin
            case (state_q)
                ST_HALT: begin
                    ir_valid_q <= 1'b0;
                end
                ST_RUN: begin
                    if (!stall) begin
                        ir_q       <= instruction;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        cnt_q      <= cnt_d;
                        // The halting instruction still issues; the PC parks on it.
                        if (jump_self || out_of_range) begin
                            state_q <= ST_HALT;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign pc_out      = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus randomized stall and
// redirect traffic, checked against a behavioural fetch model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 5;

  // Handshake: stall/redirect are sampled on the rising edge; redirect wins
  // over stall, and the IR is live exactly when ir_valid is high.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] mem [256];

  logic [7:0]  instr_a, pc_a, ir_a, ir_pc_a;
  logic        ir_valid_a, halted_a;
  logic [15:0] cnt_a;
  state_e      state_a;

  logic [7:0]  instr_b, pc_b, ir_b, ir_pc_b;
  logic        ir_valid_b, halted_b;
  logic [1:0]  cnt_b;
  state_e      state_b;

  assign instr_a = mem[pc_a];
  assign instr_b = mem[pc_b];

  fetch_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instruction(instr_a), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_a), .ir(ir_a), .ir_pc(ir_pc_a), .ir_valid(ir_valid_a),
    .halted(halted_a), .fetch_count(cnt_a), .state_o(state_a)
  );

  fetch_unit #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .instruction(instr_b), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_b), .ir(ir_b), .ir_pc(ir_pc_b), .ir_valid(ir_valid_b),
    .halted(halted_b), .fetch_count(cnt_b), .state_o(state_b)
  );

  // ---------------- reference model ----------------
  int m_pc, m_ir, m_ir_pc, m_cnt;
  bit m_irv, m_halt;

  function automatic void model_reset();
    m_pc = 0; m_ir = 0; m_ir_pc = 0; m_cnt = 0; m_irv = 0; m_halt = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit rv, input int rpc);
    int b, off, tgt;
    if (rv) begin
      m_pc = rpc; m_irv = 0; m_halt = (rpc >= DEPTH);
    end else if (m_halt) begin
      m_irv = 0;
    end else if (!st) begin
      b = int'(mem[m_pc]);
      m_ir = b; m_ir_pc = m_pc; m_irv = 1; m_cnt = m_cnt + 1;
      if (b / 64 == 3) begin
        off = b % 64;
        if (off >= 32) off = off - 64;
        tgt = (m_pc + 1 + off + 256) % 256;
      end else begin
        tgt = (m_pc + 1) % 256;
      end
      if (b == 255 || tgt >= DEPTH) m_halt = 1;
      else m_pc = tgt;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  bit sb_on = 0;
  string phase = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_all();
    check({phase, ".pc"},       32'(pc_a),       32'(m_pc));
    check({phase, ".ir"},       32'(ir_a),       32'(m_ir));
    check({phase, ".ir_pc"},    32'(ir_pc_a),    32'(m_ir_pc));
    check({phase, ".ir_valid"}, 32'(ir_valid_a), 32'(m_irv));
    check({phase, ".halted"},   32'(halted_a),   32'(m_halt));
    check({phase, ".state"},    32'(state_a),    32'(m_halt));
    check({phase, ".cnt"},      32'(cnt_a),      32'(min_i(m_cnt, 65535)));
    check({phase, ".cnt_sat"},  32'(cnt_b),      32'(min_i(m_cnt, 3)));
    check({phase, ".pc_sat"},   32'(pc_b),       32'(m_pc));
    if (sb_on && ir_valid_a) begin
      logic [15:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check({phase, ".issue"}, 32'({ir_pc_a, ir_a}), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit st, input bit rv, input int rpc);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_pc = 8'(rpc);
    @(posedge clk);
    model_edge(st, rv, rpc);
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check({phase, ".rst_pc"},  32'(pc_a),     32'd0);
    check({phase, ".rst_hlt"}, 32'(halted_a), 32'd0);
    check({phase, ".rst_cnt"}, 32'(cnt_b),    32'd0);
  endtask

  task automatic load_program();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h49; mem[1] = 8'hC1; mem[2] = 8'h18; mem[3] = 8'hA9; mem[4] = 8'h4D;
  endtask

  task automatic run_case1(input string tag);
    phase = tag;
    sb_on = 1;
    exp_q = {16'h0049, 16'h01C1, 16'h03A9, 16'h044D};
    repeat (4) step(0, 0, 0);
    check({tag, ".halted"}, 32'(halted_a), 32'd1);
    check({tag, ".count"},  32'(cnt_b),    32'd3);
    check({tag, ".drain"},  32'(exp_q.size()), 32'd0);
    sb_on = 0;
    step(0, 0, 0);
    check({tag, ".irv_drop"}, 32'(ir_valid_a), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
    load_program();
    model_reset();
    #12;
    check_all();
    release_reset();

    run_case1("c1");
    check("c1.cnt16", 32'(cnt_a), 32'd4);

    phase = "c2";
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    repeat (3) begin
      step(1, 0, 0);
      check("c2.ir_hold", 32'(ir_a), 32'hC1);
      check("c2.pc_hold", 32'(pc_a), 32'd3);
    end
    check("c2.cnt_hold", 32'(cnt_a), 32'd6);
    step(0, 0, 0);
    check("c2.after", 32'(ir_a), 32'hA9);

    phase = "c3";
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 2);
    check("c3.bubble", 32'(ir_valid_a), 32'd0);
    step(0, 0, 0);
    check("c3.tgt", 32'({ir_pc_a, ir_a}), 32'h0218);
    step(0, 0, 0);
    check("c3.next", 32'({ir_pc_a, ir_a}), 32'h03A9);

    phase = "c4";
    mem[2] = 8'hFF;
    step(0, 1, 2); step(0, 0, 0);
    check("c4.ir", 32'(ir_a), 32'hFF);
    check("c4.halt", 32'(halted_a), 32'd1);
    repeat (2) step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    check("c4.pc", 32'(pc_a), 32'd2);

    phase = "c5";
    step(0, 1, 0);
    check("c5.resume", 32'(halted_a), 32'd0);
    step(0, 0, 0);
    check("c5.ir", 32'(ir_a), 32'h49);
    step(0, 1, 7);
    check("c5.oor", 32'(halted_a), 32'd1);
    repeat (2) step(0, 0, 0);

    phase = "c6";
    mem[2] = 8'h18;
    step(0, 1, 0); step(0, 0, 0); step(1, 0, 0);
    async_reset();
    release_reset();
    run_case1("c6");
    phase = "c6h";
    async_reset();
    release_reset();

    phase = "rand";
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        case ($urandom_range(0, 3))
          0:       mem[a] = 8'hFF;
          1:       mem[a] = 8'hC0 | 8'($urandom_range(0, 63));
          default: mem[a] = 8'($urandom_range(0, 191));
        endcase
      end
      for (int k = 0; k < 100; k++) begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the 8-bit program counter and drives the memory read address. It captures the returned byte into an instruction register for the decode stage. It resolves jumps locally, accepts redirects and stalls from downstream, and halts on program end or a jump-to-self.

## Interface
- `DEPTH`, 32: number of valid instruction addresses; legal PC range is 0..DEPTH-1.
- `CNT_W`, 16: width of the fetch counter.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `instruction`, input, 8: byte returned combinationally by instruction memory for `pc_out`.
- `stall`, input, 1: downstream is not ready; hold everything.
- `redirect_valid`, input, 1: a downstream stage requests a PC change this cycle.
- `redirect_pc`, input, 8: new PC when `redirect_valid` is 1.
- `pc_out`, output, 8: current PC; wired to the memory read address.
- `ir`, output, 8: registered instruction.
- `ir_pc`, output, 8: PC from which `ir` was fetched.
- `ir_valid`, output, 1: `ir` holds a live instruction.
- `halted`, output, 1: fetch is stopped.
- `fetch_count`, output, CNT_W: number of issued instructions; saturating.

## Operation
- Encoding: opcode = instruction[7:6]; `11` = jump, offset = instruction[5:0], a signed 6-bit value.
- Sequential next PC: pc+1. Jump target: pc+1+sext(offset). All PC arithmetic is modulo 256.
- States: RUN, HALT.
- Per-edge priority:
  1. reset
  2. redirect
  3. stall
  4. normal fetch
- **Redirect** (either state, stall ignored):
  - `pc_out` <= `redirect_pc`.
  - `ir_valid` <= 0, which flushes the IR.
  - If `redirect_pc` < DEPTH, the state becomes RUN. Otherwise it becomes HALT and nothing is fetched.
  - `fetch_count` is unchanged.
- **Stall** in RUN (no redirect): PC, `ir`, `ir_pc`, `ir_valid` and `fetch_count` all hold.
- **Fetch** in RUN (no stall, no redirect):
  - `ir` <= `instruction`, `ir_pc` <= `pc_out`, `ir_valid` <= 1.
  - `fetch_count` increments, saturating at all-ones.
  - Next PC is the jump target or the sequential PC.
- **Halt conditions**, evaluated on the fetched instruction. In both cases the instruction itself is still issued and the state becomes HALT:
  - Jump with offset = -1 (byte 0xFF, i.e. jump-to-self). The PC stays at the jump's address.
  - The computed next PC is >= DEPTH. The PC holds at the last issued address.
- **HALT**:
  - `halted` = 1, `pc_out` holds.
  - `ir` and `ir_pc` hold their last values; `ir_valid` <= 0 at the first edge in HALT.
  - Stall has no effect. Only a redirect or reset leaves HALT.
- **Reset values**: `pc_out` 0, `ir` 0x00, `ir_pc` 0, `ir_valid` 0, `halted` 0, `fetch_count` 0, state RUN.

## Timing
- Memory is combinational: `instruction` must be valid in the same cycle as `pc_out`.
- Latency: a PC presented in cycle n appears on `ir`/`ir_pc` with `ir_valid`=1 after the edge ending cycle n.
- Throughput: 1 instruction/cycle. A taken jump costs no bubble, because it is resolved in the fetch cycle.
- Redirect costs exactly one bubble: `ir_valid`=0 for one cycle, then the target instruction follows.
- `halted` rises on the same edge that issues the halting instruction.
- Reset is asynchronous: all outputs go to their reset values immediately, including mid-stall and in HALT. Operation resumes at the first edge after deassertion.

## Structure
- Shared package holds:
  - opcode constants: OP_ADD `00`, OP_LW `01`, OP_SW `10`, OP_J `11`;
  - field bit positions;
  - the 6-to-8 sign-extension function;
  - the RUN/HALT state encoding.
- One sub-module, `pc_next_logic`: a combinational block computing sequential/jump target, the jump-to-self flag and the out-of-range flag.
- The top level holds the state register, PC, IR, counter and priority logic.

## Test plan
Unless a case says otherwise, DEPTH=5 and memory = {0x49, 0xC1, 0x18, 0xA9, 0x4D}.

1. Release reset, no stall.
   - Issued sequence: (0x49, pc 0), (0xC1, pc 1), (0xA9, pc 3), (0x4D, pc 4).
   - Address 2 is skipped by the jump.
   - `halted` is 1 with the 0x4D issue, `ir_valid` is 0 on the next cycle, `fetch_count` = 4.
2. Assert `stall` for 3 cycles while `ir` = 0xC1.
   - `ir` and `pc_out` (3) hold, `fetch_count` is unchanged.
   - After release, 0xA9 issues next.
3. `redirect_valid` with `redirect_pc` = 2 while stall = 1 at pc 3.
   - One bubble (`ir_valid` 0), then (0x18, pc 2), then 0xA9.
4. Place 0xFF at address 2, redirect to 2.
   - 0xFF issues, `halted` = 1, `pc_out` stays 2.
   - Further stalls or idle cycles change nothing.
5. While HALT:
   - Redirect to 0 resumes fetch with 0x49.
   - Redirect to 7 (>= DEPTH) stays halted with `ir_valid` 0.
6. Assert `reset` asynchronously mid-stream and mid-stall.
   - All outputs go to their reset values before the next edge.
   - After release, the sequence from case 1 repeats.
   - With CNT_W=2, `fetch_count` saturates at 3.
